// File: rtl/erx_pkg.sv
// Shared definitions for the eMesh receive dispatcher: packet layout, default width and helpers.
package erx_pkg;

    localparam int unsigned PKT_W        = 104;

    localparam int unsigned WRITE_LSB    = 0;
    localparam int unsigned DATAMODE_LSB = 1;
    localparam int unsigned DATAMODE_W   = 2;
    localparam int unsigned CTRLMODE_LSB = 4;
    localparam int unsigned CTRLMODE_W   = 4;
    localparam int unsigned DSTADDR_LSB  = 8;
    localparam int unsigned DSTADDR_W    = 32;
    localparam int unsigned DATA_LSB     = 40;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned SRCADDR_LSB  = 72;
    localparam int unsigned SRCADDR_W    = 32;

    // Field layout of one inbound packet, MSB first.
    typedef struct packed {
        logic [SRCADDR_W-1:0]  srcaddr;
        logic [DATA_W-1:0]     data;
        logic [DSTADDR_W-1:0]  dstaddr;
        logic [CTRLMODE_W-1:0] ctrlmode;
        logic                  rsvd;
        logic [DATAMODE_W-1:0] datamode;
        logic                  write;
    } emesh_pkt_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/erx_sfifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is always visible on dout.
module erx_sfifo
    import erx_pkg::*;
#(
    parameter int unsigned DW    = PKT_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        push,
    input  logic [DW-1:0]               din,
    input  logic                        pop,
    output logic [DW-1:0]               dout,
    output logic [clog2(DEPTH):0]       count,
    output logic                        full,
    output logic                        empty
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count_nxt;
    logic          wr_en;
    logic          rd_en;

    // Fullness is judged on the pre-pop count, so a push into a full FIFO is lost even if it pops.
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    always_comb begin
        count_nxt = count;
        if (wr_en && !rd_en) begin
            count_nxt = count + CW'(1);
        end else if (!wr_en && rd_en) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (wr_en) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_en) begin
                rptr <= rptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage is not reset; contents are only observed while non-empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= din;
        end
    end

    assign dout = mem[rptr];

endmodule

// File: rtl/erx_dispatch.sv
// Routes inbound packets to per-channel FWFT buffers by ctrlmode, with shared pushback,
// saturating drop/overflow counters and a sticky overflow flag.
module erx_dispatch
    import erx_pkg::*;
#(
    parameter int unsigned PW      = PKT_W,
    parameter int unsigned NCH     = 3,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned SEL_LSB = CTRLMODE_LSB,
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned MARGIN  = 2
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                in_access,
    input  logic [PW-1:0]       in_packet,
    output logic                in_wait,
    output logic [NCH-1:0]      out_access,
    output logic [NCH*PW-1:0]   out_packet,
    input  logic [NCH-1:0]      out_wait,
    output logic [15:0]         drop_count,
    output logic [15:0]         ovf_count,
    output logic                ovf_flag
);

    localparam int unsigned CW = clog2(DEPTH) + 1;

    logic [SEL_W-1:0]        sel;
    logic                    sel_ok;
    logic                    drop_event;
    logic                    ovf_event;
    logic [NCH-1:0]          ch_push;
    logic [NCH-1:0]          ch_pop;
    logic [NCH-1:0]          ch_full;
    logic [NCH-1:0]          ch_empty;
    logic [NCH-1:0]          ch_low;
    logic [NCH-1:0][CW-1:0]  ch_count;
    logic [NCH-1:0][CW-1:0]  ch_count_nxt;
    logic [NCH-1:0][PW-1:0]  ch_dout;

    assign sel        = in_packet[SEL_LSB +: SEL_W];
    assign sel_ok     = (32'(sel) < NCH);
    assign drop_event = in_access & ~sel_ok;
    assign ovf_event  = |(ch_push & ch_full);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign ch_push[k] = in_access & sel_ok & (sel == SEL_W'(k));
        assign ch_pop[k]  = ~ch_empty[k] & ~out_wait[k];

        erx_sfifo #(
            .DW    (PW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk    (clk),
            .nreset (nreset),
            .push   (ch_push[k]),
            .din    (in_packet),
            .pop    (ch_pop[k]),
            .dout   (ch_dout[k]),
            .count  (ch_count[k]),
            .full   (ch_full[k]),
            .empty  (ch_empty[k])
        );

        // Post-edge occupancy, used to raise pushback while MARGIN entries are still free.
        assign ch_count_nxt[k] = ch_count[k] + CW'(ch_push[k] & ~ch_full[k]) - CW'(ch_pop[k]);
        assign ch_low[k]       = (CW'(DEPTH) - ch_count_nxt[k]) <= CW'(MARGIN);

        assign out_access[k]             = ~ch_empty[k];
        assign out_packet[k*PW +: PW]    = ch_dout[k];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            in_wait    <= 1'b0;
            drop_count <= '0;
            ovf_count  <= '0;
            ovf_flag   <= 1'b0;
        end else begin
            in_wait <= |ch_low;
            if (drop_event && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
            if (ovf_event && ovf_count != 16'hFFFF) begin
                ovf_count <= ovf_count + 16'd1;
            end
            if (ovf_event) begin
                ovf_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_erx_dispatch.sv
// Scoreboard bench for erx_dispatch: directed pushes queue expected packets, a monitor checks pops.
module tb_erx_dispatch;
    import erx_pkg::*;

    localparam int unsigned PW    = 104;
    localparam int unsigned NCH   = 3;
    localparam int unsigned DEPTH = 8;

    typedef logic [PW-1:0] pkt_t;

    logic              clk;
    logic              nreset;
    logic              in_access;
    logic [PW-1:0]     in_packet;
    logic              in_wait;
    logic [NCH-1:0]    out_access;
    logic [NCH*PW-1:0] out_packet;
    logic [NCH-1:0]    out_wait;
    logic [15:0]       drop_count;
    logic [15:0]       ovf_count;
    logic              ovf_flag;

    erx_dispatch #(
        .PW      (PW),
        .NCH     (NCH),
        .DEPTH   (DEPTH),
        .SEL_LSB (4),
        .SEL_W   (3),
        .MARGIN  (2)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .in_access  (in_access),
        .in_packet  (in_packet),
        .in_wait    (in_wait),
        .out_access (out_access),
        .out_packet (out_packet),
        .out_wait   (out_wait),
        .drop_count (drop_count),
        .ovf_count  (ovf_count),
        .ovf_flag   (ovf_flag)
    );

    always #5 clk = ~clk;

    pkt_t q0[$];
    pkt_t q1[$];
    pkt_t q2[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pkt_t mon_got;
    pkt_t mon_exp;
    bit   mon_ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic pkt_t make_pkt(input int unsigned ch, input int unsigned tag);
        emesh_pkt_t p;
        p          = '0;
        p.write    = 1'b1;
        p.ctrlmode = 4'(ch);
        p.dstaddr  = 32'h8000_0000 | 32'(tag);
        p.data     = ~32'(tag);
        p.srcaddr  = 32'h5A00_0000 + 32'(tag);
        return pkt_t'(p);
    endfunction

    function automatic int qsize(input int unsigned ch);
        case (ch)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void pop_exp(input int k, output bit ok, output pkt_t p);
        ok = 1'b0;
        p  = '0;
        case (k)
            0: if (q0.size() > 0) begin p = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin p = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin p = q2.pop_front(); ok = 1'b1; end
        endcase
    endfunction

    // Drive one packet for a single cycle; acc says whether it should be buffered.
    task automatic send(input int unsigned ch, input int unsigned tag, input bit acc);
        pkt_t p;
        p         = make_pkt(ch, tag);
        in_access = 1'b1;
        in_packet = p;
        if (acc) begin
            case (ch)
                0: q0.push_back(p);
                1: q1.push_back(p);
                2: q2.push_back(p);
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        in_access = 1'b0;
    endtask

    task automatic wait_chan(input string name, input int unsigned ch);
        int i;
        i = 0;
        while (qsize(ch) != 0 && i < 64) begin
            @(posedge clk);
            #1;
            i++;
        end
        check({name, "_drained"}, 32'(qsize(ch)), 32'd0);
        check({name, "_idle"}, 32'(out_access[ch]), 32'd0);
    endtask

    // Every cycle a channel pops, its head must match the oldest expected packet.
    always @(negedge clk) begin
        if (nreset) begin
            for (int k = 0; k < NCH; k++) begin
                if (out_access[k] && !out_wait[k]) begin
                    mon_got = out_packet[k*PW +: PW];
                    pop_exp(k, mon_ok, mon_exp);
                    n_checks++;
                    if (!mon_ok) begin
                        n_fail++;
                        $display("FAIL unexpected_pop ch%0d: got %h, expected no output", k, mon_got);
                    end else if (mon_got !== mon_exp) begin
                        n_fail++;
                        $display("FAIL payload ch%0d: got %h, expected %h", k, mon_got, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        clk       = 1'b0;
        nreset    = 1'b0;
        in_access = 1'b0;
        in_packet = '0;
        out_wait  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_access", 32'(out_access), 32'd0);
        check("rst_in_wait", 32'(in_wait), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        check("rst_ovf_flag", 32'(ovf_flag), 32'd0);
        @(posedge clk);
        #1;
        nreset = 1'b1;

        // Routing by ctrlmode, latency one cycle.
        send(0, 1, 1'b1);
        check("route_ch0", 32'(out_access), 32'b001);
        send(1, 2, 1'b1);
        check("route_ch1", 32'(out_access), 32'b010);
        send(2, 3, 1'b1);
        check("route_ch2", 32'(out_access), 32'b100);

        // Unmapped channel select is dropped.
        send(5, 4, 1'b0);
        check("unmapped_no_access", 32'(out_access), 32'd0);
        check("unmapped_drop_count", 32'(drop_count), 32'd1);
        @(posedge clk);
        #1;
        check("unmapped_idle", 32'(out_access), 32'd0);

        // Stalled channel 0: pushback after 6th push, overflow on 9th and 10th.
        out_wait = 3'b001;
        for (int i = 0; i < 10; i++) begin
            send(0, 100 + i, i < 8);
            if (i == 4) check("in_wait_after_5", 32'(in_wait), 32'd0);
            if (i == 5) check("in_wait_after_6", 32'(in_wait), 32'd1);
        end
        check("ovf_count_2", 32'(ovf_count), 32'd2);
        check("ovf_flag_set", 32'(ovf_flag), 32'd1);
        check("drop_count_hold", 32'(drop_count), 32'd1);
        check("stalled_access", 32'(out_access), 32'b001);
        out_wait = 3'b000;
        wait_chan("ovf_drain_ch0", 0);
        check("in_wait_released", 32'(in_wait), 32'd0);

        // Channel 1 full: push during a pop is still discarded, leaving count 7.
        out_wait = 3'b010;
        for (int i = 0; i < 8; i++) send(1, 200 + i, 1'b1);
        check("full_in_wait", 32'(in_wait), 32'd1);
        check("full_ovf_hold", 32'(ovf_count), 32'd2);
        out_wait = 3'b000;
        send(1, 300, 1'b0);
        out_wait = 3'b010;
        check("pushpop_ovf", 32'(ovf_count), 32'd3);
        send(1, 301, 1'b1);
        check("refill_accepted", 32'(ovf_count), 32'd3);
        send(1, 302, 1'b0);
        check("refull_ovf", 32'(ovf_count), 32'd4);
        out_wait = 3'b000;
        wait_chan("full_drain_ch1", 1);

        // Channel 2 stalled while channel 0 streams.
        out_wait = 3'b100;
        for (int i = 0; i < 7; i++) send(2, 400 + i, 1'b1);
        for (int i = 0; i < 20; i++) send(0, 500 + i, 1'b1);
        wait_chan("stream_ch0", 0);
        check("stall_ch2_held", 32'(out_access), 32'b100);
        check("stream_ovf_hold", 32'(ovf_count), 32'd4);

        // Reset mid-stream flushes everything at once.
        send(0, 600, 1'b1);
        send(0, 601, 1'b1);
        nreset = 1'b0;
        #1;
        check("midrst_out_access", 32'(out_access), 32'd0);
        check("midrst_in_wait", 32'(in_wait), 32'd0);
        check("midrst_drop_count", 32'(drop_count), 32'd0);
        check("midrst_ovf_count", 32'(ovf_count), 32'd0);
        check("midrst_ovf_flag", 32'(ovf_flag), 32'd0);
        q0.delete();
        q1.delete();
        q2.delete();
        out_wait = 3'b000;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_pulse", 32'(out_access), 32'd0);
        end
        @(posedge clk);
        #1;
        nreset = 1'b1;
        check("postrst_empty", 32'(out_access), 32'd0);
        send(1, 700, 1'b1);
        check("postrst_push", 32'(out_access), 32'b010);
        wait_chan("postrst_drain", 1);
        check("postrst_ch2_flushed", 32'(out_access[2]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
